// File: rtl/uart_tx_mmio_pkg.sv
// Shared constants for the memory-mapped UART transmitter: FSM states,
// register offsets and STATUS bit positions.
package uart_pkg;

  typedef logic [1:0] tx_state_t;

  localparam tx_state_t IDLE  = 2'd0;
  localparam tx_state_t START = 2'd1;
  localparam tx_state_t DATA  = 2'd2;
  localparam tx_state_t STOP  = 2'd3;

  // Register offsets, decoded from addr[3:2]
  localparam logic [1:0] TXDATA = 2'd0;
  localparam logic [1:0] STATUS = 2'd1;
  localparam logic [1:0] CTRL   = 2'd2;

  localparam int unsigned ST_BUSY    = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_EMPTY   = 2;
  localparam int unsigned ST_OVF     = 3;
  localparam int unsigned ST_CNT_LSB = 4;
  localparam int unsigned ST_CNT_W   = 4;

  localparam int unsigned BAUD_W = 16;

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Circular-buffer FIFO with an explicit occupancy count; pushes when full
// and pops when empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage needs no reset; occupancy is tracked by count alone
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: register decode, overflow tracking,
// framing FSM and baud counter around a small transmit FIFO.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = 868,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        wr_en,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] RELOAD = BAUD_W'(BAUD_DIV - 1);

  tx_state_t         state, state_n;
  logic [BAUD_W-1:0] cnt, cnt_n;
  logic [2:0]        bit_idx, bit_n;
  logic [7:0]        shift, shift_n;
  logic              tx_n;
  logic              pop;
  logic              overflow;

  logic              push_req;
  logic              clr_req;
  logic [7:0]        fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              busy;
  logic              unused;

  assign push_req = sel && wr_en && (addr[3:2] == TXDATA);
  assign clr_req  = sel && wr_en && (addr[3:2] == CTRL) && wdata[0];
  assign unused   = ^{addr[1:0], wdata[31:8]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .din   (wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Sticky overflow; a new overflow beats a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (push_req && fifo_full) begin
      overflow <= 1'b1;
    end else if (clr_req) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      tx      <= tx_n;
    end
  end

  // Next-state logic; tx is registered from the next state so it moves with the FSM
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = fifo_dout;
          cnt_n   = RELOAD;
          state_n = START;
        end
      end
      START: begin
        if (cnt == '0) begin
          cnt_n   = RELOAD;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          cnt_n = cnt - BAUD_W'(1);
        end
      end
      DATA: begin
        if (cnt == '0) begin
          cnt_n   = RELOAD;
          shift_n = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            bit_n   = '0;
            state_n = STOP;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt - BAUD_W'(1);
        end
      end
      STOP: begin
        if (cnt == '0) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_n = fifo_dout;
            cnt_n   = RELOAD;
            state_n = START;
          end else begin
            cnt_n   = '0;
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - BAUD_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    tx_n = 1'b1;
    if (state_n == START)     tx_n = 1'b0;
    else if (state_n == DATA) tx_n = shift_n[0];
  end

  assign busy = (state != IDLE);
  assign irq  = fifo_empty && !busy;

  always_comb begin
    rdata = '0;
    if (addr[3:2] == STATUS) begin
      rdata[ST_BUSY]                   = busy;
      rdata[ST_FULL]                   = fifo_full;
      rdata[ST_EMPTY]                  = fifo_empty;
      rdata[ST_OVF]                    = overflow;
      rdata[ST_CNT_LSB +: ST_CNT_W]    = ST_CNT_W'(fifo_count);
    end
  end

endmodule
